// File: rtl/alu_op_driver_if.sv
// Handshake and ALU bus bundle for alu_op_driver.
// The master side is the driver; the slave side is the requester, consumer and ALU.
interface alu_op_driver_if #(
  parameter int WIDTH = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_code;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [WIDTH-1:0] alu_A;
  logic [WIDTH-1:0] alu_B;
  logic [4:0]       alu_code;
  logic [WIDTH-1:0] alu_C;
  logic             alu_overflow;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_overflow;
  logic             rsp_illegal;

  modport master (
    input  req_valid, req_code, req_a, req_b,
    input  alu_C, alu_overflow, rsp_ready,
    output req_ready, alu_A, alu_B, alu_code,
    output rsp_valid, rsp_result, rsp_overflow,
    output rsp_illegal
  );

  modport slave (
    output req_valid, req_code, req_a, req_b,
    output alu_C, alu_overflow, rsp_ready,
    input  req_ready, alu_A, alu_B, alu_code,
    input  rsp_valid, rsp_result, rsp_overflow,
    input  rsp_illegal
  );
endinterface

// File: rtl/alu_op_driver.sv
// Initiator for a combinational 16-bit ALU.
// It registers the operands, waits for the ALU to settle, then captures the result.
module alu_op_driver #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_op_driver_if.master  bus,
  output logic [CNT_W-1:0] ovf_count
);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("alu_op_driver: SETTLE_CYCLES must be >= 1");
  end

  localparam int CW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE, SETTLE, RESP
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [4:0]       code_q, code_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ovf_q, ovf_d;
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] ovc_q, ovc_d;

  function automatic logic is_legal(
    input logic [4:0] c
  );
    return (c inside {[5'd0:5'd5]})
        || (c inside {[5'd8:5'd10]})
        || (c == 5'd12)
        || (c inside {[5'd16:5'd19]})
        || (c inside {[5'd24:5'd29]});
  endfunction

  // Only signed arithmetic codes report overflow.
  function automatic logic keeps_ovf(
    input logic [4:0] c
  );
    return c inside {5'd0, 5'd2, 5'd4, 5'd5};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    code_d  = code_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    ill_d   = ill_q;
    ovc_d   = ovc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (is_legal(bus.req_code)) begin
            a_d     = bus.req_a;
            b_d     = bus.req_b;
            code_d  = bus.req_code;
            cnt_d   = CNT_INIT;
            state_d = SETTLE;
          end else begin
            res_d   = '0;
            ovf_d   = 1'b0;
            ill_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          res_d   = bus.alu_C;
          ovf_d   = bus.alu_overflow
                  & keeps_ovf(code_q);
          ill_d   = 1'b0;
          state_d = RESP;
          if (ovf_d && (ovc_q != '1))
            ovc_d = ovc_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      code_q  <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
      ovc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      code_q  <= code_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
      ovc_q   <= ovc_d;
    end
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.rsp_valid    = (state_q == RESP);
  assign bus.alu_A        = a_q;
  assign bus.alu_B        = b_q;
  assign bus.alu_code     = code_q;
  assign bus.rsp_result   = res_q;
  assign bus.rsp_overflow = ovf_q;
  assign bus.rsp_illegal  = ill_q;
  assign ovf_count        = ovc_q;

endmodule

// File: tb/tb_alu_op_driver.sv
// Directed bench for alu_op_driver with a small ALU model on the alu_* bus.
// Uses CNT_W=2 so that saturation of the overflow counter is reachable.
module tb_alu_op_driver;

  logic       clk;
  logic       rst;
  logic [1:0] ovf_count;
  logic [15:0] sum;
  int nvec;
  int nerr;

  alu_op_driver_if #(.WIDTH(16)) bus ();

  alu_op_driver #(
    .WIDTH(16),
    .SETTLE_CYCLES(1),
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master),
    .ovf_count(ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: add, equality, and; other codes xor with overflow raised
  always_comb begin
    sum = bus.alu_A + bus.alu_B;
    bus.alu_C = bus.alu_A ^ bus.alu_B;
    bus.alu_overflow = 1'b1;
    case (bus.alu_code)
      5'b00000: begin
        bus.alu_C = sum;
        bus.alu_overflow =
          (bus.alu_A[15] == bus.alu_B[15])
          && (sum[15] != bus.alu_A[15]);
      end
      5'b11100:
        bus.alu_C = {15'd0, bus.alu_A == bus.alu_B};
      5'b01000:
        bus.alu_C = bus.alu_A & bus.alu_B;
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic issue(
    input logic [4:0]  code,
    input logic [15:0] a,
    input logic [15:0] b
  );
    bus.req_valid = 1'b1;
    bus.req_code  = code;
    bus.req_a     = a;
    bus.req_b     = b;
    tick();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_code  = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_alu_A", bus.alu_A, 0);
    chk("rst_alu_B", bus.alu_B, 0);
    chk("rst_alu_code", bus.alu_code, 0);
    chk("rst_result", bus.rsp_result, 0);
    chk("rst_ovf_count", ovf_count, 0);

    // T1: signed add overflow, two-edge latency
    issue(5'b00000, 16'h7F00, 16'h0300);
    chk("t1_valid_e1", bus.rsp_valid, 0);
    chk("t1_ready_e1", bus.req_ready, 0);
    chk("t1_alu_A", bus.alu_A, 16'h7F00);
    chk("t1_alu_B", bus.alu_B, 16'h0300);
    tick();
    chk("t1_valid_e2", bus.rsp_valid, 1);
    chk("t1_result", bus.rsp_result, 16'h8200);
    chk("t1_ovf", bus.rsp_overflow, 1);
    chk("t1_illegal", bus.rsp_illegal, 0);
    chk("t1_ovf_count", ovf_count, 1);
    tick();
    chk("t1_idle_valid", bus.rsp_valid, 0);
    chk("t1_idle_ready", bus.req_ready, 1);
    chk("t1_alu_hold", bus.alu_A, 16'h7F00);

    // T2: equality compare, overflow masked
    issue(5'b11100, 16'h0705, 16'h0705);
    tick();
    chk("t2_eq_result", bus.rsp_result, 16'h0001);
    chk("t2_eq_ovf", bus.rsp_overflow, 0);
    chk("t2_ovf_count", ovf_count, 1);
    tick();
    issue(5'b11100, 16'h0804, 16'h0705);
    tick();
    chk("t2_ne_result", bus.rsp_result, 16'h0000);
    tick();

    // T3: illegal opcode, one-edge latency
    issue(5'b00110, 16'h1234, 16'h5678);
    chk("t3_valid", bus.rsp_valid, 1);
    chk("t3_illegal", bus.rsp_illegal, 1);
    chk("t3_result", bus.rsp_result, 0);
    chk("t3_ovf", bus.rsp_overflow, 0);
    chk("t3_alu_A", bus.alu_A, 16'h0804);
    chk("t3_alu_code", bus.alu_code, 5'b11100);
    tick();
    chk("t3_idle", bus.req_ready, 1);

    // boundary codes around the legal ranges
    issue(5'b01011, 16'h0001, 16'h0001);
    chk("b_0b_illegal", bus.rsp_illegal, 1);
    tick();
    issue(5'b11110, 16'h0001, 16'h0001);
    chk("b_1e_illegal", bus.rsp_illegal, 1);
    tick();
    issue(5'b11101, 16'h00F0, 16'h000F);
    chk("b_1d_valid_e1", bus.rsp_valid, 0);
    tick();
    chk("b_1d_illegal", bus.rsp_illegal, 0);
    chk("b_1d_result", bus.rsp_result, 16'h00FF);
    chk("b_1d_ovf_mask", bus.rsp_overflow, 0);
    tick();

    // overflow passed through on code 00010
    issue(5'b00010, 16'h0001, 16'h0002);
    tick();
    chk("m_02_ovf", bus.rsp_overflow, 1);
    chk("m_02_result", bus.rsp_result, 16'h0003);
    chk("m_02_ovf_count", ovf_count, 2);
    tick();

    // T4: response back-pressure
    bus.rsp_ready = 1'b0;
    issue(5'b01000, 16'h00FF, 16'h0F0F);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_valid", bus.rsp_valid, 1);
      chk("t4_result", bus.rsp_result, 16'h000F);
      chk("t4_ready", bus.req_ready, 0);
      tick();
    end
    chk("t4_ovf_count", ovf_count, 2);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_code  = 5'b00000;
    bus.req_a     = 16'h1111;
    tick();
    bus.req_valid = 1'b0;
    chk("t4_no_accept_A", bus.alu_A, 16'h00FF);
    chk("t4_no_accept_rdy", bus.req_ready, 1);
    chk("t4_done_valid", bus.rsp_valid, 0);

    // T5: reset while settling
    issue(5'b00000, 16'h7F00, 16'h0300);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_valid", bus.rsp_valid, 0);
    chk("t5_ready", bus.req_ready, 1);
    chk("t5_alu_A", bus.alu_A, 0);
    chk("t5_alu_B", bus.alu_B, 0);
    chk("t5_alu_code", bus.alu_code, 0);
    chk("t5_ovf_count", ovf_count, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_rsp", bus.rsp_valid, 0);
    end

    // T6: counter saturates at 3 with CNT_W=2
    for (int i = 0; i < 5; i++) begin
      issue(5'b00000, 16'h7F00, 16'h0300);
      tick();
      chk("t6_ovf_count", ovf_count,
          (i < 3) ? i + 1 : 3);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
